decode_stage: RTL and testbench

//  Instruction-decode (ID) stage of the 5-stage RV64 pipeline.
//  - Holds the IF/ID pipeline register: instruction, PC, PC+4.
//  - Splits the decoded instruction into its fields.
//  - Reads the 32x64 register file, which is also written from writeback.
//  - Produces the sign-extended immediate.

---
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage RV64 pipeline.
//   IF/ID register (InstrD/PCD/PCPlus4D) with stall/flush control, field
//   split of InstrD, 32x64 register file written from WB on the falling
//   edge, and sign-extended immediate generation.
// Ports
//   clock, reset (async active-low)
//   InstrF/PCF/PCPlus4F          fetch-side inputs to the IF/ID register
//   ImmSrcD                      immediate format: 00 I, 01 S, 10 B, 11 J
//   ResultW/reg_to_write_src/WriteEnable  writeback port into the regfile
//   FlushD/StallD                IF/ID bubble / hold (stall wins)
//   opcode/func3/func7/Rs1D/Rs2D/RdD      InstrD fields
//   read_data1/read_data2        regfile[Rs1D], regfile[Rs2D]
//   PCD/PCPlus4D/ImmExtD         registered PCs, extended immediate
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] InstrF,
  input  logic [63:0] PCF,
  input  logic [63:0] PCPlus4F,
  input  logic [1:0]  ImmSrcD,
  input  logic [63:0] ResultW,
  input  logic [4:0]  reg_to_write_src,
  input  logic        WriteEnable,
  input  logic        FlushD,
  input  logic        StallD,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [63:0] read_data1,
  output logic [63:0] read_data2,
  output logic [63:0] PCD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD,
  output logic [63:0] ImmExtD,
  output logic [63:0] PCPlus4D
);

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 64;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  ifid_t ifid_q;
  logic [31:0] instr_d;

  // ---------------- IF/ID register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      ifid_q <= '0;
    else if (!StallD)
      ifid_q <= FlushD ? '0 : ifid_t'{instr: InstrF, pc: PCF, pc_plus4: PCPlus4F};
  end

  assign instr_d  = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCPlus4D = ifid_q.pc_plus4;

  assign opcode = instr_d[6:0];
  assign RdD    = instr_d[11:7];
  assign func3  = instr_d[14:12];
  assign Rs1D   = instr_d[19:15];
  assign Rs2D   = instr_d[24:20];
  assign func7  = instr_d[31:25];

  // ---------------- register file ----------------
  // Written on the falling edge so a WB write lands mid-cycle and the same
  // cycle's ID read already sees it; no WB->ID bypass is needed.
  // Entry 0 is a hard-wired zero, so reads need no x0 special case.
  logic [NUM_REGS-1:0][XLEN-1:0] rf;

  assign rf[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic wr_hit;
    assign wr_hit = WriteEnable && (reg_to_write_src == 5'(r));

    always_ff @(negedge clock or negedge reset) begin
      if (!reset)
        rf[r] <= '0;
      else if (wr_hit)
        rf[r] <= ResultW;
    end
  end

  assign read_data1 = rf[Rs1D];
  assign read_data2 = rf[Rs2D];

  // ---------------- immediate ----------------
  logic sgn;
  assign sgn = instr_d[31];

  always_comb begin
    ImmExtD = '0;
    unique case (ImmSrcD)
      2'b00: ImmExtD = {{52{sgn}}, instr_d[31:20]};
      2'b01: ImmExtD = {{52{sgn}}, instr_d[31:25], instr_d[11:7]};
      2'b10: ImmExtD = {{52{sgn}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      2'b11: ImmExtD = {{44{sgn}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed-vector bench for decode_stage.
module tb_decode_stage;

  logic        clock, reset;
  logic [31:0] InstrF;
  logic [63:0] PCF, PCPlus4F, ResultW;
  logic [1:0]  ImmSrcD;
  logic [4:0]  reg_to_write_src;
  logic        WriteEnable, FlushD, StallD;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [63:0] read_data1, read_data2, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clock(clock), .reset(reset), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .ImmSrcD(ImmSrcD), .ResultW(ResultW),
    .reg_to_write_src(reg_to_write_src), .WriteEnable(WriteEnable),
    .FlushD(FlushD), .StallD(StallD), .opcode(opcode), .func3(func3),
    .func7(func7), .read_data1(read_data1), .read_data2(read_data2),
    .PCD(PCD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ImmExtD(ImmExtD),
    .PCPlus4D(PCPlus4D)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, settle 1ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Regfile write on the next falling edge.
  task automatic wb(input logic [4:0] rd, input logic [63:0] val);
    WriteEnable = 1'b1; reg_to_write_src = rd; ResultW = val;
    @(negedge clock);
    #1;
    WriteEnable = 1'b0;
  endtask

  task automatic load(input logic [31:0] ins, input logic [63:0] pc);
    InstrF = ins; PCF = pc; PCPlus4F = pc + 64'd4;
  endtask

  initial begin
    reset = 1'b0; InstrF = '0; PCF = '0; PCPlus4F = '0; ImmSrcD = 2'b00;
    ResultW = '0; reg_to_write_src = '0; WriteEnable = 1'b0;
    FlushD = 1'b0; StallD = 1'b0;

    // reset state
    #2;
    chk("rst_pcd", PCD, 64'd0);
    chk("rst_pc4", PCPlus4D, 64'd0);
    chk("rst_op", 64'(opcode), 64'd0);
    chk("rst_imm", ImmExtD, 64'd0);
    #1 reset = 1'b1;

    // 1: LW x10, 5(x0)
    InstrF = 32'h0050_2503; PCF = 64'd4; PCPlus4F = 64'd8; ImmSrcD = 2'b00;
    tick();
    chk("lw_op", 64'(opcode), 64'h03);
    chk("lw_f3", 64'(func3), 64'd2);
    chk("lw_rd", 64'(RdD), 64'd10);
    chk("lw_rs1", 64'(Rs1D), 64'd0);
    chk("lw_imm", ImmExtD, 64'd5);
    chk("lw_pcd", PCD, 64'd4);
    chk("lw_pc4", PCPlus4D, 64'd8);

    // 2: ADD x12,x10,x11 after writing x10=5, x11=12
    wb(5'd10, 64'd5);
    wb(5'd11, 64'd12);
    load(32'h00B5_0633, 64'h10);
    tick();
    chk("add_rd1", read_data1, 64'd5);
    chk("add_rd2", read_data2, 64'd12);
    chk("add_f7", 64'(func7), 64'd0);
    chk("add_rs1", 64'(Rs1D), 64'd10);
    chk("add_rs2", 64'(Rs2D), 64'd11);
    chk("add_rd", 64'(RdD), 64'd12);
    // write lands mid-cycle and is read in the same cycle
    wb(5'd10, 64'd77);
    chk("wbr_rd1", read_data1, 64'd77);

    // 3: SUB x13,x10,x11; x0 write discarded
    load(32'h40B5_06B3, 64'h14);
    tick();
    chk("sub_f7", 64'(func7), 64'h20);
    chk("sub_rd", 64'(RdD), 64'd13);
    chk("sub_rd1", read_data1, 64'd77);
    wb(5'd0, 64'd99);
    load(32'h0000_0033, 64'h18);
    tick();
    chk("x0_rd1", read_data1, 64'd0);
    chk("x0_rd2", read_data2, 64'd0);

    // 4: immediates (ImmSrcD is combinational on the held InstrD)
    load(32'hFFF0_0013, 64'h1C); ImmSrcD = 2'b00;
    tick();
    chk("imm_i_m1", ImmExtD, 64'hFFFF_FFFF_FFFF_FFFF);
    load(32'hFE00_0E23, 64'h20); ImmSrcD = 2'b01;
    tick();
    chk("imm_s_m4", ImmExtD, 64'hFFFF_FFFF_FFFF_FFFC);
    load(32'h0000_0423, 64'h24);
    tick();
    chk("imm_s_p8", ImmExtD, 64'd8);
    load(32'hFE00_0EE3, 64'h28); ImmSrcD = 2'b10;
    tick();
    chk("imm_b_m4", ImmExtD, 64'hFFFF_FFFF_FFFF_FFFC);
    load(32'h0000_0463, 64'h2C);
    tick();
    chk("imm_b_p8", ImmExtD, 64'd8);
    load(32'hFFDF_F06F, 64'h30); ImmSrcD = 2'b11;
    tick();
    chk("imm_j_m4", ImmExtD, 64'hFFFF_FFFF_FFFF_FFFC);
    load(32'h0080_006F, 64'h34);
    tick();
    chk("imm_j_p8", ImmExtD, 64'd8);

    // 5: flush, stall, stall-over-flush
    load(32'h00B5_0633, 64'h100);
    tick();
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0;
    chk("fl_op", 64'(opcode), 64'd0);
    chk("fl_pcd", PCD, 64'd0);
    chk("fl_pc4", PCPlus4D, 64'd0);
    chk("fl_imm", ImmExtD, 64'd0);
    load(32'h40B5_06B3, 64'h200);
    tick();
    StallD = 1'b1;
    load(32'hFFF0_0013, 64'h300);
    tick();
    tick();
    chk("st_pcd", PCD, 64'h200);
    chk("st_pc4", PCPlus4D, 64'h204);
    chk("st_f7", 64'(func7), 64'h20);
    chk("st_rd", 64'(RdD), 64'd13);
    FlushD = 1'b1;
    tick();
    chk("stfl_pcd", PCD, 64'h200);
    StallD = 1'b0; FlushD = 1'b0;
    tick();
    chk("rel_pcd", PCD, 64'h300);

    // 6: asynchronous reset mid-cycle clears IF/ID and regfile
    load(32'h00B5_0633, 64'h400); ImmSrcD = 2'b00;
    tick();
    chk("pre_rd2", read_data2, 64'd12);
    #2 reset = 1'b0;
    #1;
    chk("ar_pcd", PCD, 64'd0);
    chk("ar_pc4", PCPlus4D, 64'd0);
    chk("ar_op", 64'(opcode), 64'd0);
    reset = 1'b1;
    tick();
    chk("ar_rf1", read_data1, 64'd0);
    chk("ar_rf2", read_data2, 64'd0);
    chk("ar_pcd2", PCD, 64'h400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
